// File: rtl/ppu_mem_arbiter.sv
// PPU main-memory arbiter: three requesters (sprite, background, CPU) share a
// single registered read/write port. Fixed priority spr > bg > cpu, except that
// a CPU which has been denied STARVE_LIMIT cycles in a row jumps to the front.
// A tag pipeline routes each returning read word back to its requester.
module ppu_mem_arbiter #(
  parameter int READ_LATENCY = 3,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        spr_req_i,
  input  logic [13:0] spr_addr_i,
  output logic        spr_gnt_o,
  output logic        spr_rvalid_o,
  output logic [31:0] spr_rdata_o,
  input  logic        bg_req_i,
  input  logic [13:0] bg_addr_i,
  output logic        bg_gnt_o,
  output logic        bg_rvalid_o,
  output logic [31:0] bg_rdata_o,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [3:0]  cpu_be_i,
  input  logic [13:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  output logic        cpu_gnt_o,
  output logic        cpu_rvalid_o,
  output logic [31:0] cpu_rdata_o,
  output logic [13:0] mem_addr_o,
  output logic        mem_en_o,
  output logic [3:0]  mem_we_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  // One tag stage per cycle between grant and data return.
  localparam int         STAGES = READ_LATENCY + 1;
  localparam logic [3:0] LIMIT  = 4'(STARVE_LIMIT);
  localparam logic [1:0] ID_SPR = 2'd0;
  localparam logic [1:0] ID_BG  = 2'd1;
  localparam logic [1:0] ID_CPU = 2'd2;

  logic [3:0]              starve_cnt_q, starve_cnt_d;
  logic                    starved;
  logic                    gnt_spr, gnt_bg, gnt_cpu;
  logic                    rd_issue;
  logic [1:0]              rd_id;
  logic                    mem_en_q, mem_en_d;
  logic [13:0]             mem_addr_q, mem_addr_d;
  logic [3:0]              mem_we_q, mem_we_d;
  logic [31:0]             mem_wdata_q, mem_wdata_d;
  logic [STAGES-1:0]       tag_vld_q;
  logic [STAGES-1:0][1:0]  tag_id_q;

  assign starved = (starve_cnt_q == LIMIT);

  // Winner selection for this cycle; nothing is granted while in reset.
  always_comb begin
    gnt_spr = 1'b0;
    gnt_bg  = 1'b0;
    gnt_cpu = 1'b0;
    if (!reset_i) begin
      if (starved && cpu_req_i) gnt_cpu = 1'b1;
      else if (spr_req_i)       gnt_spr = 1'b1;
      else if (bg_req_i)        gnt_bg  = 1'b1;
      else if (cpu_req_i)       gnt_cpu = 1'b1;
    end
  end

  assign spr_gnt_o = gnt_spr;
  assign bg_gnt_o  = gnt_bg;
  assign cpu_gnt_o = gnt_cpu;

  // Read accesses get a tag; CPU writes and idle cycles insert a bubble.
  assign rd_issue = gnt_spr | gnt_bg | (gnt_cpu & ~cpu_we_i);
  assign rd_id    = gnt_spr ? ID_SPR : (gnt_bg ? ID_BG : ID_CPU);

  // Next memory-port contents; address and write data hold when unused.
  always_comb begin
    mem_en_d    = gnt_spr | gnt_bg | gnt_cpu;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 4'b0000;
    mem_wdata_d = mem_wdata_q;
    if (gnt_spr)      mem_addr_d = spr_addr_i;
    else if (gnt_bg)  mem_addr_d = bg_addr_i;
    else if (gnt_cpu) begin
      mem_addr_d = cpu_addr_i;
      if (cpu_we_i) begin
        mem_we_d    = cpu_be_i;
        mem_wdata_d = cpu_wdata_i;
      end
    end
  end

  // Count consecutive denied CPU cycles, saturating at the promotion point.
  always_comb begin
    starve_cnt_d = 4'd0;
    if (cpu_req_i && !gnt_cpu)
      starve_cnt_d = starved ? starve_cnt_q : starve_cnt_q + 4'd1;
  end

  // Memory port registers and starvation counter.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mem_en_q     <= 1'b0;
      mem_addr_q   <= 14'd0;
      mem_we_q     <= 4'b0000;
      mem_wdata_q  <= 32'd0;
      starve_cnt_q <= 4'd0;
    end else begin
      mem_en_q     <= mem_en_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Tag shift register; reset discards reads that are still in flight.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tag_vld_q <= '0;
      tag_id_q  <= '0;
    end else begin
      tag_vld_q <= {tag_vld_q[STAGES-2:0], rd_issue};
      tag_id_q  <= {tag_id_q[STAGES-2:0], rd_id};
    end
  end

  assign mem_en_o    = mem_en_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_we_o    = mem_we_q;
  assign mem_wdata_o = mem_wdata_q;

  assign spr_rvalid_o = tag_vld_q[STAGES-1] && (tag_id_q[STAGES-1] == ID_SPR);
  assign bg_rvalid_o  = tag_vld_q[STAGES-1] && (tag_id_q[STAGES-1] == ID_BG);
  assign cpu_rvalid_o = tag_vld_q[STAGES-1] && (tag_id_q[STAGES-1] == ID_CPU);

  assign spr_rdata_o = mem_rdata_i;
  assign bg_rdata_o  = mem_rdata_i;
  assign cpu_rdata_o = mem_rdata_i;

endmodule

// File: doc/ppu_mem_arbiter.md
# ppu_mem_arbiter

Shares the single read/write port of main PPU memory among three requesters: the sprite row fetcher, the background tile fetcher and the CPU interface. The arbiter grants one access per cycle using fixed priority with a CPU anti-starvation override. It drives the memory port from registers. A tag pipeline routes each returned read word to the requester that issued it, so fetch engines see a clean request/grant/rvalid handshake instead of counting memory wait states themselves.

## Interface
- READ_LATENCY, 3, cycles from the cycle mem_en is high (read) to the cycle mem_rdata is valid
- STARVE_LIMIT, 8, consecutive ungranted cpu_req cycles before the CPU is promoted to top priority
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- spr_req  in  1  sprite fetch request, held until spr_gnt
- spr_addr  in  14  sprite word address
- spr_gnt  out  1  request accepted this cycle
- spr_rvalid  out  1  spr_rdata valid
- spr_rdata  out  32  read word
- bg_req, bg_addr[13:0], bg_gnt, bg_rvalid, bg_rdata[31:0]  same semantics, background fetcher
- cpu_req  in  1  CPU access request, held until cpu_gnt
- cpu_we  in  1  1 = write, 0 = read
- cpu_be  in  4  byte enables for writes; bit n covers wdata[8n+7:8n]
- cpu_addr  in  14  word address
- cpu_wdata  in  32  write data
- cpu_gnt, cpu_rvalid, cpu_rdata[31:0]  as above; no cpu_rvalid for writes
- mem_addr  out  14  registered memory address
- mem_en  out  1  registered memory enable
- mem_we  out  4  registered per-byte write enable
- mem_wdata  out  32  registered write data
- mem_rdata  in  32  memory read data

## Operation
- Selection is combinational in cycle T, from the current req lines:
  - Normal order: spr > bg > cpu.
  - Starved order: when starve_cnt == STARVE_LIMIT, cpu > spr > bg.
- Exactly one gnt is high in a cycle, and only when its req is high. No req means no gnt.
- Issue: at the clock edge ending T, the registers load the winner's access:
  - mem_en = 1.
  - mem_addr = winner's addr.
  - mem_we = cpu_be if the winner is cpu with cpu_we = 1, else 0.
  - mem_wdata = cpu_wdata for a CPU write, else hold the previous value.
- With no winner, mem_en = 0 and mem_we = 0 in T+1.
- Tag pipeline: READ_LATENCY+1 stages, each holding {valid, id[1:0]} with id 0 = spr, 1 = bg, 2 = cpu.
  - A read grant enters valid = 1. A write or idle cycle enters valid = 0.
  - The pipeline shifts every cycle.
- Return: when the output stage is valid, the matching rvalid is high for one cycle. All three rdata outputs equal mem_rdata continuously; only rvalid qualifies them.
- starve_cnt, 4 bits wide:
  - cpu_req high and cpu_gnt low: increment, saturating at STARVE_LIMIT.
  - cpu_gnt high or cpu_req low: clear to 0.
- Requesters may issue back-to-back. A requester holding req continuously while winning gets a grant every cycle; reads pipeline fully.

## Timing
- Grant: same cycle as the winning req (combinational).
- Memory access: mem_en high in T+1.
- Read data: rvalid in T+1+READ_LATENCY, i.e. 4 cycles after gnt at the default latency.
- Writes take effect in memory at the T+1 edge. A read of the same address granted in T+1 or later returns the new data.
- Reset values:
  - mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - All tag stages invalid; starve_cnt = 0.
  - All rvalid = 0. All gnt = 0 while reset is high.
- Reset mid-operation: in-flight reads are dropped. No rvalid is asserted for any read granted before reset, even though memory may still return data.
- Simultaneous requests:
  - All three high, not starved: spr wins.
  - cpu reaches STARVE_LIMIT while spr and bg are held high: cpu wins exactly one cycle, then the counter clears and normal order resumes.
- Dropping req before gnt is legal; no access is issued.

## Test plan
- Reset release, no requests: mem_en = 0, all gnt/rvalid = 0 for 10 cycles; mem_addr = 0.
- Single bg read at addr 0x0123 in cycle 5: bg_gnt in 5; mem_en = 1, mem_addr = 0x0123 in 6; model returns 0xDEADBEEF in 9; bg_rvalid = 1 with bg_rdata = 0xDEADBEEF in 9 only.
- spr and bg both hold req for 4 reads each, from cycle 0:
  - spr granted in cycles 0–3, bg in 4–7.
  - rvalid order spr×4 (cycles 4–7), then bg×4 (cycles 8–11); data matches each address.
- cpu_req held with spr_req held continuously:
  - cpu_gnt first in the 9th cycle (after 8 denied cycles), spr_gnt low in that cycle.
  - Pattern repeats every 9 cycles.
- CPU write 0xAABBCCDD, be = 4'b0101 to 0x0010, then CPU read of 0x0010 next cycle (memory pre-filled 0x11223344):
  - mem_we = 4'b0101 in the write access cycle; no cpu_rvalid for the write.
  - The read returns 0x11BB33DD.
- Reset asserted 2 cycles after an spr read grant: no spr_rvalid ever appears for it; after release, a new spr read completes normally with 4-cycle latency.
